// File: rtl/apb_usrt_bridge.sv
// apb_usrt_bridge: APB3 slave to synchronous serial link with FIFOs, bit-clock divider, parity, sticky errors and irq.
module apb_usrt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         pClk,
  input  logic         pReset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wData,
  output logic [W-1:0] rData,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wPtr, rPtr;
  logic [PW:0] count;
  logic doPush, doPop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPop = pop & !empty;
  assign doPush = push & (!full | doPop);
  assign rData = mem[rPtr];
  always_ff @(posedge pClk)
    if (doPush) mem[wPtr] <= wData;
  always_ff @(posedge pClk or negedge pReset)
    if (!pReset) begin
      wPtr <= '0;
      rPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wPtr <= wPtr + 1'b1;
      if (doPop) rPtr <= rPtr + 1'b1;
      count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
    end
endmodule

module apb_usrt_bridge #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DIV_RESET = 40,
  localparam int REG_W = (DATA_W > 8) ? DATA_W : 8
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic [ADDR_W-1:0] pAddress,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [REG_W-1:0]  pWData,
  output logic [REG_W-1:0]  pRData,
  output logic              pReady,
  output logic              pSlvErr,
  output logic              uClk,
  output logic              sTx,
  input  logic              sRx,
  output logic              irq
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rxState_t;
  txState_t txState;
  rxState_t rxState;
  logic [1:0] regSel;
  logic access, setup, regWr;
  logic unusedAddr;
  logic txPush, txPop, txFull, txEmpty, rxPush, rxPop, rxFull, rxEmpty;
  logic [DATA_W-1:0] txData, rxData, txSh, rxSh;
  logic [BW-1:0] txBit, rxBit;
  logic txPar, rxParErr, txStep, txBusy, txStart;
  logic [6:0] ctrl;
  logic txEn, rxEn, parEn, parOdd;
  logic ovr, frm, par, ovrSet, frmSet, parSet, rxDone, statW;
  logic [REG_W-1:0] divReg, divAct, divCnt, divEff, rdMux;
  logic clkRun, tick, riseEv, fallEv;
  assign unusedAddr = ^{pAddress[ADDR_W-1:4], pAddress[1:0]};
  assign regSel = pAddress[3:2];
  assign access = pSelect & pEnable;
  assign setup = pSelect & !pEnable;
  assign regWr = access & pWrite;
  assign pReady = access;
  assign pSlvErr = access & (regSel == 2'd0) & (pWrite ? txFull : rxEmpty);
  assign txPush = regWr & (regSel == 2'd0) & !txFull;
  assign rxPop = access & !pWrite & (regSel == 2'd0) & !rxEmpty;
  assign statW = regWr & (regSel == 2'd1);
  assign txEn = ctrl[0];
  assign rxEn = ctrl[1];
  assign parEn = ctrl[2] ^ ctrl[3];
  assign parOdd = ctrl[3];
  apb_usrt_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) txFifo (
    .pClk(pClk), .pReset(pReset), .push(txPush), .pop(txPop), .wData(pWData[DATA_W-1:0]),
    .rData(txData), .full(txFull), .empty(txEmpty)
  );
  apb_usrt_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) rxFifo (
    .pClk(pClk), .pReset(pReset), .push(rxPush), .pop(rxPop), .wData(rxSh),
    .rData(rxData), .full(rxFull), .empty(rxEmpty)
  );
  assign rdMux = (regSel == 2'd0) ? (rxEmpty ? '0 : REG_W'(rxData)) :
                 (regSel == 2'd1) ? REG_W'({ovr, frm, par, rxFull, rxEmpty, txFull, txEmpty}) :
                 (regSel == 2'd2) ? REG_W'(ctrl) : divReg;
  always_ff @(posedge pClk or negedge pReset)
    if (!pReset) begin
      pRData <= '0;
      ctrl <= '0;
      divReg <= REG_W'(DIV_RESET);
      ovr <= 1'b0;
      frm <= 1'b0;
      par <= 1'b0;
      irq <= 1'b0;
    end else begin
      pRData <= (setup & !pWrite) ? rdMux : '0;
      if (regWr & (regSel == 2'd2)) ctrl <= pWData[6:0];
      if (regWr & (regSel == 2'd3)) divReg <= pWData;
      ovr <= ovrSet | (ovr & !(statW & pWData[6]));
      frm <= frmSet | (frm & !(statW & pWData[5]));
      par <= parSet | (par & !(statW & pWData[4]));
      irq <= (ctrl[4] & txEmpty) | (ctrl[5] & !rxEmpty) | (ctrl[6] & (ovr | frm | par));
    end
  // Divider reloads only at half-period boundaries so a DIV write never produces a runt phase.
  assign divEff = (divReg == '0) ? REG_W'(1) : divReg;
  assign clkRun = txEn | rxEn | txBusy;
  assign tick = clkRun & (divCnt == divAct - 1'b1);
  assign riseEv = tick & !uClk;
  assign fallEv = tick & uClk;
  always_ff @(posedge pClk or negedge pReset)
    if (!pReset) begin
      divCnt <= '0;
      divAct <= REG_W'(DIV_RESET);
      uClk <= 1'b0;
      txStep <= 1'b0;
    end else begin
      txStep <= fallEv;
      if (!clkRun) begin
        divCnt <= '0;
        divAct <= divEff;
        uClk <= 1'b0;
      end else if (tick) begin
        divCnt <= '0;
        divAct <= divEff;
        uClk <= !uClk;
      end else divCnt <= divCnt + 1'b1;
    end
  // TX keeps the bit clock alive until its frame ends, even if tx_en drops.
  assign txBusy = txState != TX_IDLE;
  assign txStart = txEn & !txEmpty;
  assign txPop = txStep & ((txState == TX_IDLE) | (txState == TX_STOP)) & txStart;
  always_ff @(posedge pClk or negedge pReset)
    if (!pReset) begin
      txState <= TX_IDLE;
      sTx <= 1'b1;
      txSh <= '0;
      txBit <= '0;
      txPar <= 1'b0;
    end else if (txStep) begin
      case (txState)
        TX_IDLE, TX_STOP: begin
          if (txStart) begin
            txSh <= txData;
            txPar <= ^txData ^ parOdd;
            sTx <= 1'b0;
            txState <= TX_START;
          end else begin
            sTx <= 1'b1;
            txState <= TX_IDLE;
          end
        end
        TX_START: begin
          sTx <= txSh[0];
          txSh <= txSh >> 1;
          txBit <= '0;
          txState <= TX_DATA;
        end
        TX_DATA: begin
          if (txBit == BW'(DATA_W-1)) begin
            sTx <= parEn ? txPar : 1'b1;
            txState <= parEn ? TX_PAR : TX_STOP;
          end else begin
            sTx <= txSh[0];
            txSh <= txSh >> 1;
            txBit <= txBit + 1'b1;
          end
        end
        TX_PAR: begin
          sTx <= 1'b1;
          txState <= TX_STOP;
        end
        default: txState <= TX_IDLE;
      endcase
    end
  assign rxDone = rxEn & riseEv & (rxState == RX_STOP);
  assign frmSet = rxDone & !sRx;
  assign parSet = rxDone & sRx & rxParErr;
  assign rxPush = rxDone & sRx & !rxParErr;
  assign ovrSet = rxPush & rxFull & !rxPop;
  always_ff @(posedge pClk or negedge pReset)
    if (!pReset) begin
      rxState <= RX_IDLE;
      rxSh <= '0;
      rxBit <= '0;
      rxParErr <= 1'b0;
    end else if (!rxEn) rxState <= RX_IDLE;
    else if (riseEv) begin
      case (rxState)
        RX_IDLE: begin
          if (!sRx) begin
            rxState <= RX_DATA;
            rxBit <= '0;
            rxParErr <= 1'b0;
          end
        end
        RX_DATA: begin
          rxSh <= {sRx, rxSh[DATA_W-1:1]};
          rxBit <= rxBit + 1'b1;
          if (rxBit == BW'(DATA_W-1)) rxState <= parEn ? RX_PAR : RX_STOP;
        end
        RX_PAR: begin
          rxParErr <= ^rxSh ^ sRx ^ parOdd;
          rxState <= RX_STOP;
        end
        default: rxState <= RX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_usrt_bridge.sv
// tb_apb_usrt_bridge: directed APB/serial vectors with hand-computed expectations.
module tb_apb_usrt_bridge;
  logic pClk = 1'b0, pReset = 1'b0;
  logic [31:0] pAddress = '0;
  logic pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [7:0] pWData = '0;
  logic [7:0] pRData;
  logic pReady, pSlvErr, uClk, sTx, sRx, irq;
  logic loop = 1'b0, rxDrv = 1'b1;
  int total = 0, bad = 0, toggles = 0;
  logic [7:0] d;
  logic e, r, ok, anyErr;
  logic [9:0] frame;
  assign sRx = loop ? sTx : rxDrv;
  always #5 pClk = !pClk;
  always @(posedge uClk or negedge uClk) if (pReset) toggles++;
  apb_usrt_bridge dut (
    .pClk(pClk), .pReset(pReset), .pAddress(pAddress), .pSelect(pSelect), .pEnable(pEnable),
    .pWrite(pWrite), .pWData(pWData), .pRData(pRData), .pReady(pReady), .pSlvErr(pSlvErr),
    .uClk(uClk), .sTx(sTx), .sRx(sRx), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic apbWrite(input logic [31:0] a, input logic [7:0] v, output logic err);
    @(negedge pClk);
    pAddress = a; pWData = v; pWrite = 1'b1; pSelect = 1'b1; pEnable = 1'b0;
    @(negedge pClk);
    pEnable = 1'b1;
    #1 err = pSlvErr;
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask
  task automatic apbRead(input logic [31:0] a, output logic [7:0] v, output logic err, output logic rdy);
    @(negedge pClk);
    pAddress = a; pWrite = 1'b0; pSelect = 1'b1; pEnable = 1'b0;
    @(negedge pClk);
    pEnable = 1'b1;
    #1 begin v = pRData; err = pSlvErr; rdy = pReady; end
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0;
  endtask
  task automatic waitEdge(input logic rise, output logic found);
    logic prev;
    found = 1'b0;
    prev = uClk;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge pClk);
      if (uClk !== prev && uClk === rise) found = 1'b1;
      prev = uClk;
    end
    if (!found) chk("uclk_wait", found, 1);
  endtask
  task automatic waitTxLow(output logic found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge pClk);
      if (sTx === 1'b0) found = 1'b1;
    end
    if (!found) chk("stx_start_wait", found, 1);
  endtask
  task automatic sendBit(input logic b);
    logic f;
    waitEdge(1'b0, f);
    rxDrv = b;
  endtask
  task automatic sendFrame(input logic [7:0] v, input logic p, input logic stp);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(v[i]);
    sendBit(p);
    sendBit(stp);
    sendBit(1'b1);
    sendBit(1'b1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge pClk);
  endtask
  initial begin
    idle(3);
    chk("rst_stx", sTx, 1);
    chk("rst_uclk", uClk, 0);
    chk("rst_irq", irq, 0);
    chk("rst_pready", pReady, 0);
    chk("rst_pslverr", pSlvErr, 0);
    chk("rst_prdata", pRData, 0);
    pReset = 1'b1;
    toggles = 0;
    apbRead(32'h4, d, e, r);
    chk("rst_stat", d, 8'h05);
    chk("rst_pready_access", r, 1);
    apbRead(32'hC, d, e, r);
    chk("rst_div", d, 40);
    apbRead(32'h8, d, e, r);
    chk("rst_ctrl", d, 0);
    idle(100);
    chk("idle_no_uclk", toggles, 0);
    // single TX frame of 0xA5 sampled mid-bit on uClk rising edges
    apbWrite(32'hC, 8'd2, e);
    apbWrite(32'h8, 8'h01, e);
    apbWrite(32'h0, 8'hA5, e);
    chk("tx_write_err", e, 0);
    waitTxLow(ok);
    for (int i = 0; i < 10; i++) begin
      waitEdge(1'b1, ok);
      frame[i] = sTx;
    end
    chk("tx_frame_a5", frame, 10'b1101001010);
    apbRead(32'h4, d, e, r);
    chk("tx_stat_empty", d, 8'h05);
    apbWrite(32'h8, 8'h00, e);
    idle(10);
    // loopback with even parity, two back-to-back frames
    loop = 1'b1;
    apbWrite(32'h8, 8'h07, e);
    apbWrite(32'h0, 8'h3C, e);
    apbWrite(32'h0, 8'h81, e);
    idle(200);
    apbRead(32'h4, d, e, r);
    chk("lb_stat", d, 8'h01);
    apbRead(32'h0, d, e, r);
    chk("lb_rx0", d, 8'h3C);
    chk("lb_rx0_err", e, 0);
    apbRead(32'h0, d, e, r);
    chk("lb_rx1", d, 8'h81);
    apbRead(32'h4, d, e, r);
    chk("lb_stat_after", d, 8'h05);
    // parity and framing errors on hand-driven frames
    loop = 1'b0;
    rxDrv = 1'b1;
    apbWrite(32'h8, 8'h06, e);
    sendFrame(8'h55, 1'b1, 1'b1);
    apbRead(32'h4, d, e, r);
    chk("err_par", d, 8'h15);
    sendFrame(8'h55, 1'b0, 1'b0);
    apbRead(32'h4, d, e, r);
    chk("err_frm", d, 8'h35);
    apbWrite(32'h4, 8'h70, e);
    apbRead(32'h4, d, e, r);
    chk("err_w1c", d, 8'h05);
    // TX FIFO full with serial side stopped, then RX overflow via loopback
    apbWrite(32'h8, 8'h00, e);
    idle(5);
    anyErr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      apbWrite(32'h0, 8'(i * 8'h11), e);
      anyErr |= e;
    end
    chk("ovf_fill_err", anyErr, 0);
    apbWrite(32'h0, 8'h55, e);
    chk("ovf_txfull_slverr", e, 1);
    apbRead(32'h4, d, e, r);
    chk("ovf_stat_txfull", d, 8'h06);
    loop = 1'b1;
    apbWrite(32'h8, 8'h07, e);
    idle(40);
    apbWrite(32'h0, 8'h55, e);
    chk("ovf_fifth_write", e, 0);
    idle(400);
    apbRead(32'h4, d, e, r);
    chk("ovf_stat", d, 8'h49);
    for (int i = 1; i <= 4; i++) begin
      apbRead(32'h0, d, e, r);
      chk("ovf_word", d, 8'(i * 8'h11));
    end
    apbRead(32'h4, d, e, r);
    chk("ovf_stat_drained", d, 8'h45);
    apbWrite(32'h4, 8'h40, e);
    apbRead(32'h4, d, e, r);
    chk("ovf_w1c", d, 8'h05);
    // empty read error and rx interrupt
    apbRead(32'h0, d, e, r);
    chk("empty_rd_err", e, 1);
    chk("empty_rd_data", d, 0);
    apbWrite(32'h8, 8'h27, e);
    idle(3);
    chk("irq_idle", irq, 0);
    apbWrite(32'h0, 8'h5A, e);
    idle(80);
    chk("irq_rx", irq, 1);
    apbRead(32'h0, d, e, r);
    chk("irq_word", d, 8'h5A);
    idle(3);
    chk("irq_clear", irq, 0);
    // asynchronous reset in the middle of a frame
    apbWrite(32'h0, 8'h00, e);
    waitTxLow(ok);
    idle(6);
    #2 pReset = 1'b0;
    #1 chk("midrst_stx", sTx, 1);
    chk("midrst_uclk", uClk, 0);
    idle(2);
    pReset = 1'b1;
    apbRead(32'h4, d, e, r);
    chk("midrst_stat", d, 8'h05);
    apbRead(32'h8, d, e, r);
    chk("midrst_ctrl", d, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
